// File: rtl/qtable_pkg.sv
// Shared definitions for the Q-table bank: default geometry, clear-FSM encoding and row-index helper.
// The QTABLE_WR_FWD_EN build option lives in qtable_bram_bank.
package qtable_pkg;
  localparam int QT_L_WIDTH    = 4;
  localparam int QT_Q_WIDTH    = 16;
  localparam int QT_ADDR_WIDTH = 32;
  localparam int QT_N_LEVEL    = 2 ** (QT_L_WIDTH / 2);
  localparam int QT_D_WIDTH    = QT_Q_WIDTH * QT_N_LEVEL;
  localparam int QT_BE_WIDTH   = QT_D_WIDTH / 8;
  localparam int QT_ROW_SHIFT  = $clog2(QT_BE_WIDTH);
  localparam int QT_ROW_W      = 2 * QT_L_WIDTH;
  localparam int QT_DEPTH      = 2 ** QT_ROW_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Byte address to row index for the default geometry; upper bits wrap.
  function automatic logic [QT_ROW_W-1:0] qt_row_of(input logic [QT_ADDR_WIDTH-1:0] addr);
    return addr[QT_ROW_SHIFT +: QT_ROW_W];
  endfunction
endpackage

// File: rtl/qtable_tdp_ram.sv
// One Q-table bank: byte-enabled port A (separate read/write rows), full-row port B, both read-first.
// Storage is never reset; only the read registers are.
module qtable_tdp_ram #(
  parameter  int DW    = 64,
  parameter  int AW    = 8,
  localparam int BW    = DW / 8,
  localparam int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_a_raddr,
  input  logic [AW-1:0] i_a_waddr,
  input  logic [BW-1:0] i_a_we,
  input  logic [DW-1:0] i_a_wdata,
  output logic [DW-1:0] o_a_rdata,
  input  logic          i_b_en,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic [DW-1:0] o_b_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  always_ff @(posedge clk) begin
    for (int k = 0; k < BW; k++) begin
      if (i_a_we[k]) r_mem[i_a_waddr][8*k +: 8] <= i_a_wdata[8*k +: 8];
    end
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_rdata <= r_mem[i_a_raddr];
      if (i_b_en) r_b_rdata <= r_mem[i_b_addr];
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;
endmodule

// File: rtl/qtable_bram_bank.sv
// Four-bank Q-table store with clear sweep and host readout.
// Define QTABLE_WR_FWD_EN to bypass same-row port A writes onto D_road0..3.
module qtable_bram_bank
  import qtable_pkg::*;
#(
  parameter  int L_WIDTH    = QT_L_WIDTH,
  parameter  int Q_WIDTH    = QT_Q_WIDTH,
  parameter  int ADDR_WIDTH = QT_ADDR_WIDTH,
  localparam int N_LEVEL    = 2 ** (L_WIDTH / 2),
  localparam int D_WIDTH    = Q_WIDTH * N_LEVEL,
  localparam int BE_WIDTH   = D_WIDTH / 8,
  localparam int ROW_SHIFT  = $clog2(BE_WIDTH),
  localparam int ROW_W      = 2 * L_WIDTH,
  localparam int DEPTH      = 2 ** ROW_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0]    D_road0,
  output logic [D_WIDTH-1:0]    D_road1,
  output logic [D_WIDTH-1:0]    D_road2,
  output logic [D_WIDTH-1:0]    D_road3,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0]    D_new,
  input  logic [BE_WIDTH-1:0]   wen_bram0,
  input  logic [BE_WIDTH-1:0]   wen_bram1,
  input  logic [BE_WIDTH-1:0]   wen_bram2,
  input  logic [BE_WIDTH-1:0]   wen_bram3,
  input  logic                  host_en,
  input  logic [1:0]            host_bank,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [D_WIDTH-1:0]    host_rdata,
  output logic                  host_rvalid
);
  localparam int HI = ROW_SHIFT + ROW_W;

  logic [ROW_W-1:0]    w_rd_row, w_wr_row, w_host_row, w_b_addr;
  logic [BE_WIDTH-1:0] w_wen    [4];
  logic [D_WIDTH-1:0]  w_dout_a [4];
  logic [D_WIDTH-1:0]  w_dout_b [4];
  logic [D_WIDTH-1:0]  w_road   [4];
  logic                w_host_rd, w_b_we;
  logic                w_unused;

  clr_state_t       r_state;
  logic [ROW_W-1:0] r_ctr;
  logic             r_busy;
  logic             r_host_rvalid;
  logic [1:0]       r_host_bank;

  assign w_rd_row   = rd_addr[ROW_SHIFT +: ROW_W];
  assign w_wr_row   = wr_addr[ROW_SHIFT +: ROW_W];
  assign w_host_row = host_addr[ROW_SHIFT +: ROW_W];
  assign w_unused   = ^{rd_addr[ADDR_WIDTH-1:HI], rd_addr[ROW_SHIFT-1:0],
                        wr_addr[ADDR_WIDTH-1:HI], wr_addr[ROW_SHIFT-1:0],
                        host_addr[ADDR_WIDTH-1:HI], host_addr[ROW_SHIFT-1:0]};

  assign w_wen[0] = wen_bram0;
  assign w_wen[1] = wen_bram1;
  assign w_wen[2] = wen_bram2;
  assign w_wen[3] = wen_bram3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ctr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_ctr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_ctr <= r_ctr + 1'b1;
          if (r_ctr == ROW_W'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port B belongs to the sweep while clearing; host requests are dropped then.
  assign w_host_rd = host_en && (r_state == ST_IDLE);
  assign w_b_we    = (r_state == ST_CLEAR);
  assign w_b_addr  = w_b_we ? r_ctr : w_host_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_rvalid <= 1'b0;
      r_host_bank   <= '0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) r_host_bank <= host_bank;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    qtable_tdp_ram #(.DW(D_WIDTH), .AW(ROW_W)) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_a_raddr (w_rd_row),
      .i_a_waddr (w_wr_row),
      .i_a_we    (w_wen[g]),
      .i_a_wdata (D_new),
      .o_a_rdata (w_dout_a[g]),
      .i_b_en    (w_host_rd),
      .i_b_we    (w_b_we),
      .i_b_addr  (w_b_addr),
      .i_b_wdata ('0),
      .o_b_rdata (w_dout_b[g])
    );
  end

`ifdef QTABLE_WR_FWD_EN
  logic [BE_WIDTH-1:0] r_fwd_be [4];
  logic [D_WIDTH-1:0]  r_fwd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_data <= '0;
      for (int b = 0; b < 4; b++) r_fwd_be[b] <= '0;
    end else begin
      r_fwd_data <= D_new;
      for (int b = 0; b < 4; b++) r_fwd_be[b] <= (w_rd_row == w_wr_row) ? w_wen[b] : '0;
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_road[b] = w_dout_a[b];
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (r_fwd_be[b][k]) w_road[b][8*k +: 8] = r_fwd_data[8*k +: 8];
      end
    end
  end
`else
  always_comb begin
    for (int b = 0; b < 4; b++) w_road[b] = w_dout_a[b];
  end
`endif

  assign D_road0     = w_road[0];
  assign D_road1     = w_road[1];
  assign D_road2     = w_road[2];
  assign D_road3     = w_road[3];
  assign host_rdata  = w_dout_b[r_host_bank];
  assign host_rvalid = r_host_rvalid;
  assign busy        = r_busy;
endmodule

// File: doc/qtable_bram_bank.md
Name: qtable_bram_bank

Overview:
- Q-table storage stage directly downstream and upstream of the Accelerator.
- Holds four banks, one per road, each row holding N_LEVEL Q-values of Q_WIDTH bits.
- Serves the Accelerator's rd_addr with registered D_road0..3 and accepts its byte-enabled writes (wr_addr, D_new, wen_bram0..3).
- Adds a hardware clear sweep and a low-priority host readout port for dumping the learned table.

Parameters:
- L_WIDTH, 4, level-code width. State index = 2*L_WIDTH bits, so depth = 2**(2*L_WIDTH) = 256.
- Q_WIDTH, 16, width of one Q-value.
- ADDR_WIDTH, 32, byte-address width of rd_addr/wr_addr/host_addr.
- Derived, not overridable:
  - N_LEVEL = 2**(L_WIDTH/2).
  - D_WIDTH = Q_WIDTH*N_LEVEL (64).
  - BE_WIDTH = D_WIDTH/8 (8).
  - ROW_SHIFT = log2(BE_WIDTH) (3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  pulse: start clear sweep of all four banks.
- busy  out  1  high while the sweep runs; the Accelerator must not issue reads/writes while high.
- rd_addr  in  ADDR_WIDTH  byte read address from the Accelerator.
- D_road0, D_road1, D_road2, D_road3  out  D_WIDTH each  registered row read from banks 0..3.
- wr_addr  in  ADDR_WIDTH  byte write address.
- D_new  in  D_WIDTH  write data, shared by all banks.
- wen_bram0, wen_bram1, wen_bram2, wen_bram3  in  BE_WIDTH each  per-bank byte write enables.
- host_en  in  1  host read request, one cycle.
- host_bank  in  2  bank select.
- host_addr  in  ADDR_WIDTH  host byte address.
- host_rdata  out  D_WIDTH  host read data.
- host_rvalid  out  1  one-cycle strobe qualifying host_rdata.

Behaviour:
- Row index: addr[ROW_SHIFT+2*L_WIDTH-1 : ROW_SHIFT]. Low ROW_SHIFT bits and upper bits are ignored, so addresses wrap modulo depth.
- Port A (Accelerator):
  - Read latency is exactly 1 cycle: D_roadN at cycle t+1 reflects rd_addr at cycle t.
  - Reads run every cycle; there is no enable.
  - Write: for each bank N and byte k with wen_brammN[k]=1, byte k of the row is updated from D_new[8k+7:8k] at the clock edge.
  - Banks are independent. Multiple wen vectors may be active in the same cycle and all are written; there is no priority.
  - Same-row read and write in the same cycle is read-first: D_roadN returns the old data unless WR_FWD is enabled.
- Port B (host/clear):
  - host_en is sampled on the edge. Next cycle, host_rvalid=1 and host_rdata holds the selected bank/row.
  - Read-first semantics also apply against a simultaneous port A write.
- Clear FSM, states IDLE, CLEAR:
  - IDLE -> CLEAR on clr=1. busy asserts on the following cycle and the row counter starts at 0.
  - CLEAR: each cycle, zero row ctr in all four banks via port B, then increment ctr.
  - At ctr = depth-1, write that row and return to IDLE. busy is high for exactly depth cycles (256).
  - clr while in CLEAR is ignored; it does not restart the sweep.
  - host_en during CLEAR is dropped and host_rvalid stays 0.
  - Port A writes during CLEAR still execute, but results are undefined; the bench treats this as a protocol violation.
- Reset (asynchronous):
  - D_road0..3 = 0, host_rdata = 0, host_rvalid = 0, busy = 0, FSM = IDLE, ctr = 0.
  - Memory contents are NOT reset.
  - Reset mid-sweep aborts it, leaving a partially cleared table. Software re-issues clr.
- Memory is inferred as true-dual-port block RAM: one array per bank, byte-write style.

Optional Feature:
- Macro: QTABLE_WR_FWD_EN.
- Defined: on a port A same-cycle read/write to the same row, each byte lane with its wen bit set returns D_new on D_roadN. Unwritten lanes return the stored data. Read-after-write for the Accelerator's update-then-read sequence therefore needs no stall.
- Undefined: pure read-first, with no bypass mux.
- Host port never forwards in either build.

Decomposition:
- Shared package qtable_pkg:
  - Derived localparams N_LEVEL, D_WIDTH, BE_WIDTH, ROW_SHIFT, DEPTH.
  - Row-index extraction function.
  - FSM state encoding.
- One natural sub-module: qtable_tdp_ram, a single-bank byte-enabled true-dual-port RAM instantiated four times.
- Top level holds the clear FSM, host mux, and forwarding logic.

Test Plan:
- Reset then clr:
  - busy high for 256 cycles.
  - Then read every row of every bank via rd_addr = row<<3; expect D_road0..3 = 0.
- Write then read:
  - wr_addr=0x28, D_new=0x1111_2222_3333_4444, wen_bram2=8'hFF.
  - Next cycle rd_addr=0x28 gives D_road2 = that value, with the other banks unchanged.
- Byte enables:
  - wen_bram0=8'h0F, D_new=0xAAAA_BBBB_CCCC_DDDD on a cleared row.
  - Read gives D_road0=0x0000_0000_CCCC_DDDD.
- Same-cycle collision, rd_addr=wr_addr=0x10, wen_bram1=8'hFF:
  - Without the macro, D_road1 returns the old value.
  - With QTABLE_WR_FWD_EN, D_road1 returns D_new.
- Host dump:
  - host_en=1, host_bank=2, host_addr=0x28 after the write test.
  - One cycle later host_rvalid=1 and host_rdata=0x1111_2222_3333_4444.
  - host_en during busy gives no rvalid.
- Async reset at sweep row 100:
  - busy drops immediately and outputs are 0.
  - Rows 100..255 keep their prior contents; rows 0..99 read 0.
